divider_integer_signed_arbiter: RTL
===================================

Name: divider_integer_signed_arbiter

Overview:
Shares one signed integer divider (quotient plus remainder, multi-cycle, valid/ready on both sides) among REQUESTER_COUNT requesters.
- Accepts one request at a time using round-robin priority.
- Latches the operands and launches the divider.
- Captures the quotient and remainder, then returns them to the granted requester only.
- Handles divide-by-zero locally, without using the divider.
- Sits between client pipelines and a single divider instance in the arithmetic subsystem.

Parameters:
WORD_WIDTH, 0, operand and result width (two's complement); must be >0.
REQUESTER_COUNT, 0, number of requesters; must be >=2.

Ports:
clock  in  1  single clock; all logic is on its rising edge.
clear  in  1  synchronous active-high reset; must also drive the shared divider's clear at the parent level.
requests_valid  in  REQUESTER_COUNT  per-requester request valid.
requests_ready  out  REQUESTER_COUNT  per-requester accept; at most one bit high.
dividends  in  REQUESTER_COUNT*WORD_WIDTH  packed; requester i occupies [i*WORD_WIDTH +: WORD_WIDTH].
divisors  in  REQUESTER_COUNT*WORD_WIDTH  packed, same layout.
responses_valid  out  REQUESTER_COUNT  one-hot or zero; result valid for the granted requester.
responses_ready  in  REQUESTER_COUNT  per-requester result accept.
quotient  out  WORD_WIDTH  broadcast result, meaningful only with responses_valid.
remainder  out  WORD_WIDTH  broadcast result.
divide_by_zero  out  1  qualifies the current response.
divider_input_valid  out  1  operand valid to the divider.
divider_input_ready  in  1  operand ready from the divider.
divider_dividend  out  WORD_WIDTH  latched dividend.
divider_divisor  out  WORD_WIDTH  latched divisor.
divider_output_valid  in  1  result valid from the divider.
divider_output_ready  out  1  result accept to the divider.
divider_quotient  in  WORD_WIDTH  divider quotient.
divider_remainder  in  WORD_WIDTH  divider remainder.

Behaviour:
- States are IDLE, ISSUE, WAIT and RESPOND. The state, grant, priority pointer, operand and result registers are all registered.
- Reset: clear=1 forces IDLE on the next edge.
  - All outputs go low/zero: requests_ready, responses_valid, divider_input_valid, divider_output_ready, divide_by_zero, quotient, remainder.
  - The priority pointer goes to requester 0.
  - clear overrides every other event, in any state.
- IDLE:
  - requests_ready is a combinational one-hot grant: the first valid requester at or after the pointer, searching upward with wrap.
  - On that cycle, latch the granted index and operands.
  - If the latched divisor is zero: set divide_by_zero, quotient=0, remainder=dividend, and go to RESPOND. The divider is untouched.
  - Otherwise go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: divider_input_valid=1. On divider_input_ready=1, go to WAIT.
- WAIT: divider_output_ready=1. On divider_output_valid=1, capture divider_quotient and divider_remainder unchanged and go to RESPOND.
- RESPOND:
  - responses_valid[grant]=1; quotient, remainder and divide_by_zero are held stable.
  - On responses_ready[grant]=1: go to IDLE and set pointer = grant+1, wrapping to 0 after REQUESTER_COUNT-1.
  - responses_ready bits of other requesters are ignored.
- Handshake rules:
  - requests_ready and responses_valid are never high in the same cycle.
  - Requesters must not make requests_valid depend on requests_ready.
  - Operands are sampled only in the accept cycle; later changes are ignored.
- Latency, counting the accept cycle as 0:
  - Nonzero divisor: divider_input_valid rises at cycle 1. responses_valid rises one cycle after the divider output handshake.
  - Zero divisor: responses_valid rises at cycle 1.
  - After a response handshake, the next accept occurs no earlier than the following cycle (one bubble cycle through IDLE).
- Fairness: a continuously requesting requester waits at most REQUESTER_COUNT-1 other services.
- Mid-operation clear: the divider is cleared by the same signal, so no stale divider_output_valid can be accepted afterwards. Any in-flight request is lost and its requester must re-request.

Decomposition:
- Shared package holds:
  - the state encoding constants: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESPOND=2'b11;
  - the index width function clog2(REQUESTER_COUNT).
- One sub-module: arbiter_round_robin_priority. It is purely combinational: request mask plus pointer in, one-hot grant and binary index out. It is reused by other shared-resource schedulers.
- The operand multiplexer is an instance of the existing word multiplexer.

Test Plan:
1. WORD_WIDTH=8, REQUESTER_COUNT=4; requester 1 only sends -7/2 (0xF9/0x02) -> responses_valid=4'b0010, quotient=0xFD, remainder=0xFF, divide_by_zero=0.
2. All four hold valid after reset, with responses_ready held high -> service order 0,1,2,3. Then requesters 0 and 2 request -> order 0,2, and exactly one requests_ready bit is high per accept.
3. Requester 3 sends 5/0 -> divider_input_valid never rises; responses_valid=4'b1000 at cycle 1 with divide_by_zero=1, quotient=0x00, remainder=0x05.
4. Requester 2 sends 100/-7, then holds responses_ready low for 10 cycles -> quotient=0xF2 and remainder=0x02 stay stable. No requests_ready or divider_input_valid during the stall, even with other requests pending.
5. Pulse clear during WAIT -> next cycle all valid/ready outputs are 0 and the pointer is 0. A following request 9/3 from requester 0 returns quotient=0x03, remainder=0x00.
6. Divider model holds divider_input_ready low for 5 cycles -> divider_input_valid, divider_dividend and divider_divisor stay stable until the handshake completes.

Source files
------------

// File: rtl/divider_integer_signed_arbiter_pkg.sv
// Shared definitions for the signed-divider arbiter.
//   state_e : FSM state encoding (IDLE, ISSUE, WAIT, RESPOND)
//   clog2   : width of a binary index able to address 'value' items
package divider_integer_signed_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    RESPOND = 2'b11
  } state_e;

  // Never returns less than 1 so that an index register always has a bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << width) < value) width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/divider_integer_signed_arbiter_arbiter_round_robin_priority.sv
// Combinational round-robin picker.
//   requests_i : request mask, one bit per requester
//   pointer_i  : requester holding highest priority this cycle
//   grant_o    : one-hot grant (zero when no request)
//   index_o    : binary index of the granted requester
//   valid_o    : at least one request was granted
// Searches upward from pointer_i with wrap-around; first hit wins.
module arbiter_round_robin_priority #(
  parameter int REQUESTER_COUNT = 4,
  parameter int INDEX_WIDTH     = 2
) (
  input  logic [REQUESTER_COUNT-1:0] requests_i,
  input  logic [INDEX_WIDTH-1:0]     pointer_i,
  output logic [REQUESTER_COUNT-1:0] grant_o,
  output logic [INDEX_WIDTH-1:0]     index_o,
  output logic                       valid_o
);

  always_comb begin
    // NOTE: every output gets a default before the search loop; a path that
    // leaves an always_comb output unassigned infers a latch.
    grant_o = '0;
    index_o = '0;
    valid_o = 1'b0;
    for (int offset = 0; offset < REQUESTER_COUNT; offset++) begin
      int candidate;
      candidate = int'(pointer_i) + offset;
      if (candidate >= REQUESTER_COUNT) candidate = candidate - REQUESTER_COUNT;
      if (!valid_o && requests_i[INDEX_WIDTH'(candidate)]) begin
        valid_o                            = 1'b1;
        grant_o[INDEX_WIDTH'(candidate)]   = 1'b1;
        index_o                            = INDEX_WIDTH'(candidate);
      end
    end
  end

endmodule

// File: rtl/divider_integer_signed_arbiter.sv
// Shares one multi-cycle signed divider among REQUESTER_COUNT requesters.
//   clock, clear                    : clock and synchronous active-high reset
//   requests_valid/ready            : per-requester operand handshake
//   dividends, divisors             : packed operands, requester i at [i*W +: W]
//   responses_valid/ready           : per-requester result handshake
//   quotient, remainder, divide_by_zero : broadcast result of the granted requester
//   divider_input_*                 : operand handshake towards the shared divider
//   divider_output_*, divider_quotient/remainder : result handshake from the divider
// A zero divisor is answered locally (q=0, r=dividend) without touching the divider.
module divider_integer_signed_arbiter
  import divider_integer_signed_arbiter_pkg::*;
#(
  // Defaults exist only so the block elaborates standalone; parents set both.
  parameter int WORD_WIDTH      = 8,
  parameter int REQUESTER_COUNT = 4
) (
  input  logic                                  clock,
  input  logic                                  clear,
  input  logic [REQUESTER_COUNT-1:0]            requests_valid,
  output logic [REQUESTER_COUNT-1:0]            requests_ready,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] dividends,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] divisors,
  output logic [REQUESTER_COUNT-1:0]            responses_valid,
  input  logic [REQUESTER_COUNT-1:0]            responses_ready,
  output logic [WORD_WIDTH-1:0]                 quotient,
  output logic [WORD_WIDTH-1:0]                 remainder,
  output logic                                  divide_by_zero,
  output logic                                  divider_input_valid,
  input  logic                                  divider_input_ready,
  output logic [WORD_WIDTH-1:0]                 divider_dividend,
  output logic [WORD_WIDTH-1:0]                 divider_divisor,
  input  logic                                  divider_output_valid,
  output logic                                  divider_output_ready,
  input  logic [WORD_WIDTH-1:0]                 divider_quotient,
  input  logic [WORD_WIDTH-1:0]                 divider_remainder
);

  localparam int INDEX_WIDTH = clog2(REQUESTER_COUNT);

  state_e                     state_q;
  logic [INDEX_WIDTH-1:0]     grant_q;
  logic [INDEX_WIDTH-1:0]     pointer_q;
  logic [INDEX_WIDTH-1:0]     pointer_d;
  logic [WORD_WIDTH-1:0]      dividend_q;
  logic [WORD_WIDTH-1:0]      divisor_q;
  logic [WORD_WIDTH-1:0]      quotient_q;
  logic [WORD_WIDTH-1:0]      remainder_q;
  logic                       divide_by_zero_q;

  logic [REQUESTER_COUNT-1:0] pick_grant;
  logic [INDEX_WIDTH-1:0]     pick_index;
  logic                       pick_valid;
  logic [WORD_WIDTH-1:0]      pick_dividend;
  logic [WORD_WIDTH-1:0]      pick_divisor;

  arbiter_round_robin_priority #(
    .REQUESTER_COUNT (REQUESTER_COUNT),
    .INDEX_WIDTH     (INDEX_WIDTH)
  ) u_arbiter (
    .requests_i (requests_valid),
    .pointer_i  (pointer_q),
    .grant_o    (pick_grant),
    .index_o    (pick_index),
    .valid_o    (pick_valid)
  );

  // Operand word multiplexer driven by the winning index.
  assign pick_dividend = dividends[int'(pick_index)*WORD_WIDTH +: WORD_WIDTH];
  assign pick_divisor  = divisors[int'(pick_index)*WORD_WIDTH +: WORD_WIDTH];

  // Priority moves to the requester just after the one being served.
  assign pointer_d = (grant_q == INDEX_WIDTH'(REQUESTER_COUNT - 1)) ? '0
                                                                    : grant_q + 1'b1;

  // Grant is only offered while idle, so it can never coincide with a response.
  assign requests_ready = (state_q == IDLE) ? pick_grant : '0;

  always_comb begin
    responses_valid = '0;
    if (state_q == RESPOND) responses_valid[grant_q] = 1'b1;
  end

  assign divider_input_valid  = (state_q == ISSUE);
  assign divider_output_ready = (state_q == WAIT);
  assign divider_dividend     = dividend_q;
  assign divider_divisor      = divisor_q;
  assign quotient             = quotient_q;
  assign remainder            = remainder_q;
  assign divide_by_zero       = divide_by_zero_q;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q          <= IDLE;
      grant_q          <= '0;
      pointer_q        <= '0;
      dividend_q       <= '0;
      divisor_q        <= '0;
      quotient_q       <= '0;
      remainder_q      <= '0;
      divide_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q    <= pick_index;
            dividend_q <= pick_dividend;
            divisor_q  <= pick_divisor;
            if (pick_divisor == '0) begin
              divide_by_zero_q <= 1'b1;
              quotient_q       <= '0;
              remainder_q      <= pick_dividend;
              state_q          <= RESPOND;
            end else begin
              divide_by_zero_q <= 1'b0;
              state_q          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (divider_input_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (divider_output_valid) begin
            quotient_q  <= divider_quotient;
            remainder_q <= divider_remainder;
            state_q     <= RESPOND;
          end
        end
        RESPOND: begin
          if (responses_ready[grant_q]) begin
            pointer_q <= pointer_d;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
